// File: rtl/skeeball_pkg.sv
// Shared types and constants for the skeeball lane controller.
// States, hole bit positions, point values and a saturating add.
package skeeball_pkg;

  localparam int SCORE_W   = 8;
  localparam int NUM_HOLES = 7;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    LOCK,
    OVER
  } state_t;

  localparam int HOLE_GUTTER = 0;
  localparam int HOLE_1      = 1;
  localparam int HOLE_2      = 2;
  localparam int HOLE_3      = 3;
  localparam int HOLE_4      = 4;
  localparam int HOLE_5      = 5;
  localparam int HOLE_10     = 6;

  localparam logic [3:0] PTS_GUTTER = 4'd0;
  localparam logic [3:0] PTS_1      = 4'd1;
  localparam logic [3:0] PTS_2      = 4'd2;
  localparam logic [3:0] PTS_3      = 4'd3;
  localparam logic [3:0] PTS_4      = 4'd4;
  localparam logic [3:0] PTS_5      = 4'd5;
  localparam logic [3:0] PTS_10     = 4'd10;

  // 9-bit add, clamped to all-ones on carry out
  function automatic logic [SCORE_W-1:0] sat_add(
    input logic [SCORE_W-1:0] a,
    input logic [3:0]         p
  );
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {{(SCORE_W-3){1'b0}}, p};
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/skeeball_hole_sync.sv
// Hole sensor synchroniser, rising-edge detect and priority encoder.
// Registered hit output: raw bit sampled at edge N gives hit at N+2.
module skeeball_hole_sync
  import skeeball_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_HOLES-1:0] holes,
  output logic                 hit_valid,
  output logic [3:0]           hit_points
);

  logic [NUM_HOLES-1:0] sync1;
  logic [NUM_HOLES-1:0] sync2;
  logic [NUM_HOLES-1:0] prev;
  logic [NUM_HOLES-1:0] edges;
  logic                 valid_n;
  logic [3:0]           points_n;

  // two-flop synchroniser plus delayed copy for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= holes;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edges = sync2 & ~prev;

  // highest-value hole wins when several rise together
  always_comb begin
    valid_n  = |edges;
    points_n = PTS_GUTTER;
    if (edges[HOLE_10])      points_n = PTS_10;
    else if (edges[HOLE_5])  points_n = PTS_5;
    else if (edges[HOLE_4])  points_n = PTS_4;
    else if (edges[HOLE_3])  points_n = PTS_3;
    else if (edges[HOLE_2])  points_n = PTS_2;
    else if (edges[HOLE_1])  points_n = PTS_1;
    else                     points_n = PTS_GUTTER;
  end

  // register the encoded hit for the controller
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_valid  <= 1'b0;
      hit_points <= '0;
    end else begin
      hit_valid  <= valid_n;
      hit_points <= points_n;
    end
  end

endmodule

// File: rtl/skeeball_game_ctrl.sv
// Skeeball lane game sequencer: start, scoring, ball count,
// lockout window, game-over hold and session high score.
module skeeball_game_ctrl
  import skeeball_pkg::*;
#(
  parameter int NUM_BALLS     = 9,
  parameter int LOCKOUT_CYC   = 1000,
  parameter int OVER_HOLD_CYC = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] holes,
  output logic [SCORE_W-1:0]   score,
  output logic [3:0]           balls_left,
  output logic [SCORE_W-1:0]   high_score,
  output logic                 game_active,
  output logic                 game_over,
  output logic                 ball_pulse,
  output logic                 new_high
);

  localparam int CNT_MAX =
    (LOCKOUT_CYC > OVER_HOLD_CYC) ? LOCKOUT_CYC : OVER_HOLD_CYC;
  localparam int CNT_W = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYC - 1);
  localparam logic [CNT_W-1:0] OVER_LAST = CNT_W'(OVER_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       BALLS_INIT = 4'(NUM_BALLS);

  logic               hit_valid;
  logic [3:0]         hit_points;

  logic               start_s1;
  logic               start_s2;
  logic               start_prev;
  logic               start_edge;

  state_t             state_q, state_n;
  logic [SCORE_W-1:0] score_q, score_n;
  logic [3:0]         balls_q, balls_n;
  logic [SCORE_W-1:0] high_q, high_n;
  logic               new_high_q, new_high_n;
  logic               pulse_q, pulse_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;

  skeeball_hole_sync u_hole_sync (
    .clk        (clk),
    .reset      (reset),
    .holes      (holes),
    .hit_valid  (hit_valid),
    .hit_points (hit_points)
  );

  // start button synchroniser and edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_s1   <= 1'b0;
      start_s2   <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      start_s1   <= start;
      start_s2   <= start_s1;
      start_prev <= start_s2;
    end
  end

  assign start_edge = start_s2 & ~start_prev;

  // controller state, score, ball and timer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      score_q    <= '0;
      balls_q    <= '0;
      high_q     <= '0;
      new_high_q <= 1'b0;
      pulse_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_n;
      score_q    <= score_n;
      balls_q    <= balls_n;
      high_q     <= high_n;
      new_high_q <= new_high_n;
      pulse_q    <= pulse_n;
      cnt_q      <= cnt_n;
    end
  end

  // next-state and datapath updates for each game phase
  always_comb begin
    state_n    = state_q;
    score_n    = score_q;
    balls_n    = balls_q;
    high_n     = high_q;
    new_high_n = new_high_q;
    pulse_n    = 1'b0;
    cnt_n      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_n    = PLAY;
          score_n    = '0;
          balls_n    = BALLS_INIT;
          new_high_n = 1'b0;
          cnt_n      = '0;
        end
      end
      PLAY: begin
        if (hit_valid) begin
          state_n = LOCK;
          score_n = sat_add(score_q, hit_points);
          balls_n = (balls_q != 4'd0) ? balls_q - 4'd1 : 4'd0;
          pulse_n = 1'b1;
          cnt_n   = '0;
        end
      end
      LOCK: begin
        if (cnt_q == LOCK_LAST) begin
          cnt_n = '0;
          if (balls_q == 4'd0) begin
            state_n = OVER;
            if (score_q > high_q) begin
              high_n     = score_q;
              new_high_n = 1'b1;
            end else begin
              new_high_n = 1'b0;
            end
          end else begin
            state_n = PLAY;
          end
        end else begin
          cnt_n = cnt_q + CNT_ONE;
        end
      end
      OVER: begin
        if (start_edge) begin
          state_n    = PLAY;
          score_n    = '0;
          balls_n    = BALLS_INIT;
          new_high_n = 1'b0;
          cnt_n      = '0;
        end else if (cnt_q == OVER_LAST) begin
          state_n    = IDLE;
          new_high_n = 1'b0;
          cnt_n      = '0;
        end else begin
          cnt_n = cnt_q + CNT_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign score       = score_q;
  assign balls_left  = balls_q;
  assign high_score  = high_q;
  assign ball_pulse  = pulse_q;
  assign new_high    = new_high_q;
  assign game_active = (state_q == PLAY) || (state_q == LOCK);
  assign game_over   = (state_q == OVER);

endmodule
